// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32-entry register file with write-through bypass and RAW busy scoreboard
module regfile_scoreboard #(
  parameter int DATA_BITS = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  output logic [DATA_BITS-1:0] rs1_data,
  output logic [DATA_BITS-1:0] rs2_data,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 stall,
  output logic [31:0]          busy_vec
);
  logic [DATA_BITS-1:0] regs [NUM_REGS];
  logic [31:0] busy, busy_set, busy_clr;
  logic byp1, byp2;
  always_comb begin
    byp1     = wr_en && wr_addr == rs1_addr;
    byp2     = wr_en && wr_addr == rs2_addr;
    rs1_data = rs1_addr == 5'd0 ? '0 : byp1 ? wr_data : regs[rs1_addr];
    rs2_data = rs2_addr == 5'd0 ? '0 : byp2 ? wr_data : regs[rs2_addr];
    busy_set = issue_valid ? 32'd1 << issue_rd : 32'd0;
    busy_clr = wr_en ? 32'd1 << wr_addr : 32'd0;
    stall    = (rs1_used && busy[rs1_addr] && !byp1) || (rs2_used && busy[rs2_addr] && !byp2);
    busy_vec = busy;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
      busy <= ((busy & ~busy_clr) | busy_set) & ~32'd1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of reads, writes, bypass, scoreboard and reset
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
  logic        rs1_used, rs2_used, wr_en, issue_valid;
  logic [31:0] rs1_data, rs2_data, wr_data, busy_vec;
  logic        stall;
  int checks = 0;
  int failures = 0;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; issue_valid = 0; issue_rd = 0;
    tick;
    reset = 0;
    rs1_used = 1; rs2_used = 1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      chk("reset_rs1", rs1_data, 32'h0);
      chk("reset_rs2", rs2_data, 32'h0);
      chk("reset_stall", {31'd0, stall}, 32'h0);
    end
    chk("reset_busy", busy_vec, 32'h0);
    rs1_used = 0; rs2_used = 0;

    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    tick;
    wr_en = 0; rs1_addr = 5; #1;
    chk("wr_x5", rs1_data, 32'hDEADBEEF);

    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; rs2_addr = 0; #1;
    chk("x0_bypass", rs2_data, 32'h0);
    tick;
    wr_en = 0; #1;
    chk("x0_read", rs2_data, 32'h0);

    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rs1_addr = 7; rs2_addr = 5; #1;
    chk("bypass_x7", rs1_data, 32'hA5A5A5A5);
    chk("no_bypass_x5", rs2_data, 32'hDEADBEEF);
    tick;
    wr_en = 0; #1;
    chk("stored_x7", rs1_data, 32'hA5A5A5A5);

    issue_valid = 1; issue_rd = 3;
    tick;
    issue_valid = 0;
    chk("busy_x3", busy_vec, 32'h0000_0008);
    rs1_addr = 3; rs1_used = 1; #1;
    chk("raw_stall_rs1", {31'd0, stall}, 32'h1);
    rs1_used = 0; #1;
    chk("unused_no_stall", {31'd0, stall}, 32'h0);
    rs2_addr = 3; rs2_used = 1; #1;
    chk("raw_stall_rs2", {31'd0, stall}, 32'h1);
    rs2_used = 0; rs1_used = 1;
    wr_en = 1; wr_addr = 3; wr_data = 32'h55; #1;
    chk("resolved_no_stall", {31'd0, stall}, 32'h0);
    chk("resolved_bypass", rs1_data, 32'h55);
    tick;
    wr_en = 0; #1;
    chk("busy_x3_cleared", busy_vec, 32'h0);
    chk("no_stall_after_wb", {31'd0, stall}, 32'h0);
    chk("stored_x3", rs1_data, 32'h55);
    rs1_used = 0;

    issue_valid = 1; issue_rd = 9;
    tick;
    chk("busy_x9", busy_vec, 32'h0000_0200);
    wr_en = 1; wr_addr = 9; wr_data = 32'h1;
    tick;
    wr_en = 0; issue_valid = 0; rs1_addr = 9; #1;
    chk("setclr_data", rs1_data, 32'h1);
    chk("setclr_busy", busy_vec, 32'h0000_0200);
    wr_en = 1; wr_addr = 9; wr_data = 32'h2;
    tick;
    wr_en = 0; #1;
    chk("x9_retired", busy_vec, 32'h0);

    issue_valid = 1; issue_rd = 0;
    tick;
    issue_valid = 0;
    chk("x0_never_busy", busy_vec, 32'h0);

    wr_en = 1; wr_addr = 4; wr_data = 32'h77;
    tick;
    wr_en = 0; issue_valid = 1; issue_rd = 4;
    tick;
    issue_rd = 10;
    tick;
    issue_valid = 0; rs1_addr = 4; rs1_used = 1; #1;
    chk("pre_reset_busy", busy_vec, 32'h0000_0410);
    chk("pre_reset_x4", rs1_data, 32'h77);
    chk("pre_reset_stall", {31'd0, stall}, 32'h1);
    reset = 1; wr_en = 1; wr_addr = 4; wr_data = 32'h99; issue_valid = 1; issue_rd = 12;
    tick;
    reset = 0; wr_en = 0; issue_valid = 0; rs2_addr = 5; #1;
    chk("midreset_busy", busy_vec, 32'h0);
    chk("midreset_x4", rs1_data, 32'h0);
    chk("midreset_stall", {31'd0, stall}, 32'h0);
    chk("midreset_x5", rs2_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32-entry integer register file for the RISCAT core, with two read ports and one write port.
- Replaces the discrete demux1to32 write fan-out and mux32to1 read selection around register storage.
- Adds a per-register busy scoreboard so decode can detect read-after-write hazards against in-flight producers.
- Sits between decode (read/issue side) and writeback (write side).

Parameters:
DATA_BITS, 32, width of each register and of all data ports
NUM_REGS, 32, number of architectural registers; fixed at 32 (addresses are 5 bits)

Ports:
clk  input  1  single core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rs1_addr  input  5  read port 1 register index
rs2_addr  input  5  read port 2 register index
rs1_used  input  1  current instruction reads rs1 (qualifies hazard check)
rs2_used  input  1  current instruction reads rs2 (qualifies hazard check)
rs1_data  output  DATA_BITS  read port 1 data, combinational
rs2_data  output  DATA_BITS  read port 2 data, combinational
wr_en  input  1  writeback strobe
wr_addr  input  5  writeback destination index
wr_data  input  DATA_BITS  writeback value
issue_valid  input  1  an instruction with a destination issues this cycle
issue_rd  input  5  destination index of the issuing instruction
stall  output  1  hazard: a used source is busy and not resolved this cycle
busy_vec  output  32  scoreboard bits, bit i = register i busy (debug/verification)

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset (reset=1 at a rising edge):
  - all registers cleared to 0;
  - busy_vec cleared to 0;
  - in-flight wr_en and issue_valid in that cycle are ignored.
- Reset outputs after reset: rs1_data=rs2_data=0 for any address, stall=0, busy_vec=0.
- Register x0:
  - reads always return 0;
  - writes to index 0 are discarded;
  - issue_rd=0 never sets busy; busy_vec[0] is constant 0.
- Read path:
  - purely combinational, zero latency.
  - Write-through bypass: if wr_en=1 and wr_addr==rsN_addr!=0, rsN_data=wr_data in the same cycle. Otherwise rsN_data is the stored value.
- Write path:
  - on the rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data;
  - the value is visible from storage the next cycle.
- Scoreboard, per register i!=0, evaluated each edge:
  - set: issue_valid=1 and issue_rd==i;
  - clear: wr_en=1 and wr_addr==i;
  - set and clear on the same i in the same cycle: set wins. The busy bit stays 1, because the new producer supersedes the retiring one.
  - neither: hold.
  - Only one outstanding producer per register is tracked. Writeback to a register that is not busy still writes data; busy stays 0.
- Hazard:
  - stall = (rs1_used & busy[rs1_addr] & ~(wr_en & wr_addr==rs1_addr)) | (the same term for rs2).
  - Combinational; busy[0] is 0, so x0 never stalls.
  - A source resolved by a same-cycle writeback does not stall, and is supplied by the bypass.
- stall does not gate issue_valid internally. Decode must deassert issue_valid while stall=1; behaviour otherwise is undefined by design.
- Reset mid-operation: outstanding busy bits are lost. The pipeline flushes on the same reset, so no late writeback is expected.
- Storage is flops with registered write only. No X is allowed on outputs after reset.

Test Plan:
- Reset then read: assert reset for 1 cycle; read all 32 addresses -> every rs1_data/rs2_data=0, busy_vec=0, stall=0.
- Write/read and x0 guard:
  - wr x5=0xDEADBEEF -> next cycle rs1_addr=5 returns 0xDEADBEEF;
  - wr x0=0x12345678 -> rs2_addr=0 returns 0.
- Bypass: same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rs1_addr=7 -> rs1_data=0xA5A5A5A5 before the edge; stored x7 also 0xA5A5A5A5 next cycle.
- RAW stall:
  - issue_rd=3 -> busy_vec[3]=1;
  - next cycle rs1_addr=3, rs1_used=1 -> stall=1;
  - rs1_used=0 -> stall=0;
  - wr x3=0x55 with rs1_addr=3 -> stall=0, rs1_data=0x55;
  - busy_vec[3]=0 afterwards.
- Simultaneous set/clear: busy x9 outstanding; same cycle wr x9=0x1 and issue_valid, issue_rd=9 -> x9 reads 0x1 next cycle, busy_vec[9] stays 1.
- Reset mid-flight: busy x4 and x10 set, x4=0x77 stored; assert reset with wr_en=1, wr_addr=4 -> busy_vec=0, x4 reads 0, stall=0.
